ns_gnrl_burst_arb: RTL and testbench

- N-port burst arbiter that shares one downstream valid/ready channel among N upstream requesters.
- Round-robin winner selection; the grant is held for a whole burst, which ends on the beat carrying last.
- Sits in front of a shared datapath resource and presents a single source-tagged stream.
- Replaces per-cycle grant toggling where bursts must not be interleaved.

---
 rtl/ns_gnrl_burst_arb.sv | 146 ++++++++++++++
 tb/tb_ns_gnrl_burst_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ns_gnrl_burst_arb.sv
// rtl/ns_gnrl_burst_arb.sv - round-robin burst arbiter, grant held until last beat
// Optional: define NS_BURST_ARB_MAXLEN_EN to release the grant after MAX_BEATS beats.
module ns_gnrl_burst_arb #(
    parameter int ARBT_NUM  = 4,
    parameter int DW        = 32,
    parameter int IDW       = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ARBT_NUM-1:0]    req_valid,
    input  logic [ARBT_NUM-1:0]    req_last,
    input  logic [ARBT_NUM*DW-1:0] req_data,
    output logic [ARBT_NUM-1:0]    req_ready,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    output logic                   out_last,
    output logic [IDW-1:0]         out_src,
    input  logic                   out_ready,
    output logic [ARBT_NUM-1:0]    grt_vec,
    output logic                   busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    if (((1 << IDW) < ARBT_NUM) || (ARBT_NUM < 2) || (MAX_BEATS < 1)) begin : g_cfg_chk
        $error("ns_gnrl_burst_arb: illegal parameter combination");
    end

    logic [0:0]          state_q, state_d;
    logic [ARBT_NUM-1:0] grt_q, grt_d;
    logic [IDW-1:0]      src_q, src_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      lo_idx, hi_idx, win_idx;
    logic                hi_found;
    logic                xfer, rel_burst, cap_hit;

    // Winner: lowest requester at or above ptr, else lowest requester overall (wrap).
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = ARBT_NUM - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
            end
            if (req_valid[i] && (i >= int'(ptr_q))) begin
                hi_idx   = IDW'(i);
                hi_found = 1'b1;
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    // grt_q is zero outside LOCK, so the AND-OR mux also zeroes the datapath when idle.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        for (int i = 0; i < ARBT_NUM; i++) begin
            if (grt_q[i]) begin
                out_data  = out_data | req_data[i*DW +: DW];
                out_valid = out_valid | req_valid[i];
                out_last  = out_last | req_last[i];
            end
        end
    end

    assign req_ready = grt_q & {ARBT_NUM{out_ready}};
    assign out_src   = src_q;
    assign grt_vec   = grt_q;
    assign busy      = (state_q == S_LOCK);
    assign xfer      = out_valid & out_ready;
    assign rel_burst = xfer & (out_last | cap_hit);

`ifdef NS_BURST_ARB_MAXLEN_EN
    localparam int CW = $clog2(MAX_BEATS) + 1;
    logic [CW-1:0] cnt_q, cnt_d;

    assign cap_hit = (cnt_q == CW'(MAX_BEATS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (rel_burst) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign cap_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grt_d   = grt_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    state_d = S_LOCK;
                    grt_d   = {{(ARBT_NUM-1){1'b0}}, 1'b1} << win_idx;
                    src_d   = win_idx;
                end
            end
            S_LOCK: begin
                if (rel_burst) begin
                    state_d = S_IDLE;
                    grt_d   = '0;
                    src_d   = '0;
                    ptr_d   = (src_q == IDW'(ARBT_NUM - 1)) ? '0 : src_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grt_d   = '0;
                src_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grt_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grt_q   <= grt_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_ns_gnrl_burst_arb.sv
// tb/tb_ns_gnrl_burst_arb.sv - directed bench with per-cycle arbitration model and beat log
module tb_ns_gnrl_burst_arb;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int MB  = 4;
`ifdef NS_BURST_ARB_MAXLEN_EN
    localparam bit MAXLEN = 1'b1;
`else
    localparam bit MAXLEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            out_valid, out_last, out_ready;
    logic [DW-1:0]   out_data;
    logic [IDW-1:0]  out_src;
    logic [N-1:0]    grt_vec;
    logic            busy;

    ns_gnrl_burst_arb #(.ARBT_NUM(N), .DW(DW), .IDW(IDW), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .grt_vec(grt_vec), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    int m_g = -1, m_ptr = 0, m_cnt = 0;
    logic [31:0] sdat [N][32];
    bit          slast[N][32];
    int          sgap [N][32];
    int          wr[N], rd[N], gapc[N];
    int          log_src[64];
    logic [31:0] log_dat[64];
    int          log_cyc[64];
    int          nlog = 0;
    bit          or_pat[4];
    int          or_len = 1;
    int          bub = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input bit l, input int g);
        sdat[p][wr[p]]  = d;
        slast[p][wr[p]] = l;
        sgap[p][wr[p]]  = g;
        if (rd[p] == wr[p]) gapc[p] = g;
        wr[p]++;
    endtask

    task automatic burst(input int p, input int id, input int nb, input int gap_beat, input int gap);
        for (int b = 0; b < nb; b++)
            push(p, 32'((p << 24) | (id << 8) | b), (b == nb - 1), (b == gap_beat) ? gap : 0);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i] && gapc[i] == 0) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = slast[i][rd[i]];
                req_data[i*DW +: DW]  = sdat[i][rd[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = 32'hDEAD0000 | i;
            end
        end
        out_ready = or_pat[cyc % or_len];
    endtask

    task automatic step();
        logic [N-1:0]  popped;
        logic [N-1:0]  e_grt, e_rdy;
        logic          e_v, e_l;
        logic [31:0]   e_d;
        int            nxt;
        @(negedge clk);
        if (rst) begin
            m_g = -1; m_ptr = 0; m_cnt = 0;
        end
        if (m_g < 0) begin
            e_v = 0; e_l = 0; e_d = '0; e_grt = '0; e_rdy = '0;
        end else begin
            e_v   = req_valid[m_g];
            e_l   = req_last[m_g];
            e_d   = req_data[m_g*DW +: DW];
            e_grt = N'(1) << m_g;
            e_rdy = out_ready ? e_grt : '0;
        end
        chk("out_valid", out_valid, e_v);
        chk("out_data",  out_data,  e_d);
        chk("out_last",  out_last,  e_l);
        chk("out_src",   out_src,   (m_g < 0) ? 0 : m_g);
        chk("grt_vec",   grt_vec,   e_grt);
        chk("req_ready", req_ready, e_rdy);
        chk("busy",      busy,      (m_g >= 0));
        if (busy && grt_vec == 4'b0010 && !out_valid) bub++;
        popped = req_valid & req_ready;
        if (!rst && out_valid && out_ready && nlog < 64) begin
            log_src[nlog] = int'(out_src);
            log_dat[nlog] = out_data;
            log_cyc[nlog] = cyc;
            nlog++;
        end
        if (!rst) begin
            if (m_g < 0) begin
                nxt = -1;
                for (int k = 0; k < N; k++)
                    if (nxt < 0 && req_valid[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
                m_g = nxt;
            end else if (req_valid[m_g] && out_ready) begin
                m_cnt++;
                if (req_last[m_g] || (MAXLEN && m_cnt == MB)) begin
                    m_ptr = (m_g + 1) % N;
                    m_g   = -1;
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (popped[i]) begin
                rd[i]++;
                gapc[i] = (rd[i] < wr[i]) ? sgap[i][rd[i]] : 0;
            end else if (rd[i] < wr[i] && gapc[i] > 0) begin
                gapc[i]--;
            end
        end
        drive();
    endtask

    task automatic run(input int maxc);
        int c = 0;
        bit pend = 1'b1;
        while (pend && c < maxc) begin
            step();
            c++;
            pend = (m_g >= 0);
            for (int i = 0; i < N; i++) if (rd[i] < wr[i]) pend = 1'b1;
        end
        if (pend) begin
            n_vec++; n_err++;
            $display("FAIL run_timeout: traffic still pending after %0d cycles", maxc);
        end
    endtask

    task automatic chk_beat(input string nm, input int k, input int es, input logic [31:0] ed);
        if (k >= nlog) begin
            n_vec++; n_err++;
            $display("FAIL %s: beat %0d missing, only %0d logged", nm, k, nlog);
        end else begin
            chk({nm, "_src"}, log_src[k], es);
            chk({nm, "_data"}, log_dat[k], ed);
        end
    endtask

    initial begin
        int          base;
        int          rr_src[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [31:0] rr_dat[10] = '{32'h00000000, 32'h00000001, 32'h01000000, 32'h01000001,
                                    32'h02000000, 32'h02000001, 32'h03000000, 32'h03000001,
                                    32'h00000100, 32'h00000101};
`ifdef NS_BURST_ARB_MAXLEN_EN
        int          ml_src[7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [31:0] ml_dat[7] = '{32'h00000B00, 32'h00000B01, 32'h00000B02, 32'h00000B03,
                                   32'h01000B00, 32'h00000B04, 32'h00000B05};
`else
        int          ml_src[7] = '{0, 0, 0, 0, 0, 0, 1};
        logic [31:0] ml_dat[7] = '{32'h00000B00, 32'h00000B01, 32'h00000B02, 32'h00000B03,
                                   32'h00000B04, 32'h00000B05, 32'h01000B00};
`endif
        for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; gapc[i] = 0; end
        or_pat = '{1, 1, 1, 1};
        or_len = 1;
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b1;

        // Reset with all ports requesting, then round-robin 2-beat bursts
        burst(0, 0, 2, 0, 0);
        burst(1, 0, 2, 0, 0);
        burst(2, 0, 2, 0, 0);
        burst(3, 0, 2, 0, 0);
        burst(0, 1, 2, 0, 0);
        drive();
        repeat (3) step();
        chk("reset_grt_vec", grt_vec, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_req_ready", req_ready, 4'b0000);
        chk("reset_out_src", out_src, 2'd0);
        rst = 1'b0;
        step();
        chk("first_grant", grt_vec, 4'b0001);
        chk("first_src", out_src, 2'd0);
        run(200);
        chk("rr_count", nlog, 10);
        for (int k = 0; k < 10; k++) chk_beat("rr", k, rr_src[k], rr_dat[k]);
        for (int k = 0; k < 8; k += 2) begin
            chk("rr_burst_len", log_cyc[k+1] - log_cyc[k], 1);
            chk("rr_idle_gap", log_cyc[k+2] - log_cyc[k], 3);
        end

        // Reset mid-burst: beat 1 must not be lost or transferred during reset
        base = nlog;
        burst(1, 5, 3, 0, 0);
        drive();
        step();
        step();
        chk("midrst_beat0", nlog - base, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", req_ready, 4'b0000);
        chk("midrst_grt", grt_vec, 4'b0000);
        step();
        rst = 1'b0;
        run(100);
        chk("midrst_count", nlog - base, 3);
        for (int k = 0; k < 3; k++) chk_beat("midrst", base + k, 1, 32'h01000500 | k);

        // Lock under toggling backpressure while port 0 waits
        base = nlog;
        or_pat = '{1, 0, 1, 0};
        or_len = 4;
        burst(2, 2, 4, 0, 0);
        burst(0, 7, 1, 0, 0);
        drive();
        run(100);
        chk("lock_count", nlog - base, 5);
        for (int k = 0; k < 4; k++) chk_beat("lock", base + k, 2, 32'h02000200 | k);
        chk_beat("lock_tail", base + 4, 0, 32'h00000700);
        or_len = 1;
        or_pat = '{1, 1, 1, 1};

        // Source bubble: port 1 holds valid low for 3 cycles after beat 0
        base = nlog;
        bub = 0;
        burst(1, 6, 3, 1, 3);
        burst(3, 6, 1, 0, 0);
        drive();
        run(100);
        chk("bubble_cycles", bub, 3);
        for (int k = 0; k < 3; k++) chk_beat("bubble", base + k, 1, 32'h01000600 | k);
        chk_beat("bubble_tail", base + 3, 3, 32'h03000600);

        // Pointer wrap: after port 3, port 0 beats port 3
        base = nlog;
        burst(3, 8, 1, 0, 0);
        drive();
        run(50);
        burst(0, 10, 1, 0, 0);
        burst(3, 10, 1, 0, 0);
        drive();
        run(50);
        chk_beat("wrap_a", base, 3, 32'h03000800);
        chk_beat("wrap_b", base + 1, 0, 32'h00000A00);
        chk_beat("wrap_c", base + 2, 3, 32'h03000A00);

        // Long burst on port 0 while port 1 requests
        base = nlog;
        burst(0, 11, 6, 0, 0);
        burst(1, 11, 1, 0, 0);
        drive();
        run(100);
        chk("maxlen_count", nlog - base, 7);
        for (int k = 0; k < 7; k++) chk_beat("maxlen", base + k, ml_src[k], ml_dat[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
